seg_mux_scheduler: RTL

Time-multiplexing scheduler that shares one `segment` hex-to-seven-segment decoder between two common-anode digits. Each digit's 4-bit value is latched, presented to the shared decoder during a blanking interval, then displayed for a dwell period with only that digit's anode enabled. The block sits between the digit-value sources (switches or counters) and the single `segment` instance; the decoder's `seg[6:0]` drives both digits' cathodes directly.

---
 rtl/seg_mux_scheduler.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/seg_mux_scheduler.sv
// seg_mux_scheduler
// -----------------
// Time-multiplexes one shared hex-to-seven-segment decoder between two
// common-anode digits. Each digit's value is latched into `s` when its
// blanking interval starts. During the blanking interval both anodes are
// off, so the decoder can settle. The digit's anode is then enabled for
// REFRESH_CYCLES cycles.
//
// Parameters:
//   REFRESH_CYCLES - dwell per digit with its anode on, in clk cycles (>= 1)
//   BLANK_CYCLES   - dead time before each dwell with both anodes off (>= 1)
//
// Ports:
//   clk        - system clock
//   reset      - synchronous, active-low reset
//   enable     - run the scan; low forces IDLE and a dark display
//   s0, s1     - hex values for digit 0 / digit 1
//   s          - value presented to the shared decoder
//   anode0_n   - digit 0 enable, active-low
//   anode1_n   - digit 1 enable, active-low
//   digit_sel  - digit currently owning the decoder
//   frame_tick - one-cycle pulse on the final SHOW1 cycle of each frame
//
// All outputs are registered. Each output is derived from the next-state
// values, so after an edge it reflects the state entered at that edge.

module seg_mux_scheduler #(
  parameter int unsigned REFRESH_CYCLES = 50000,
  parameter int unsigned BLANK_CYCLES   = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
  output logic [3:0] s,
  output logic       anode0_n,
  output logic       anode1_n,
  output logic       digit_sel,
  output logic       frame_tick
);

  localparam int unsigned MAX_CYCLES =
    (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
  // With both parameters at 1, $clog2 returns 0. Keep at least one counter bit.
  localparam int unsigned CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = '0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BLANK0 = 3'd1,
    ST_SHOW0  = 3'd2,
    ST_BLANK1 = 3'd3,
    ST_SHOW1  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       s_q, s_d;
  logic             anode0_n_q, anode0_n_d;
  logic             anode1_n_q, anode1_n_d;
  logic             digit_sel_q, digit_sel_d;
  logic             frame_tick_q, frame_tick_d;

  // Next state, dwell counter and decoder-value latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    if (!enable) begin
      // Dropping enable darkens the display at the next edge.
      // The latched value is kept.
      state_d = ST_IDLE;
      cnt_d   = CNT_ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK0;
          cnt_d   = BLANK_LOAD;
          s_d     = s0;
        end
        ST_BLANK0: begin
          if (cnt_q == CNT_ZERO) begin
            state_d = ST_SHOW0;
            cnt_d   = SHOW_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_SHOW0: begin
          if (cnt_q == CNT_ZERO) begin
            state_d = ST_BLANK1;
            cnt_d   = BLANK_LOAD;
            s_d     = s1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_BLANK1: begin
          if (cnt_q == CNT_ZERO) begin
            state_d = ST_SHOW1;
            cnt_d   = SHOW_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_SHOW1: begin
          if (cnt_q == CNT_ZERO) begin
            state_d = ST_BLANK0;
            cnt_d   = BLANK_LOAD;
            s_d     = s0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  // Output decode from the next state, so each registered output matches
  // the state entered at the same edge. Each anode is driven only by its
  // own SHOW state, so both anodes can never be on at once.
  always_comb begin
    anode0_n_d   = 1'b1;
    anode1_n_d   = 1'b1;
    digit_sel_d  = 1'b0;
    frame_tick_d = 1'b0;
    case (state_d)
      ST_SHOW0: begin
        anode0_n_d = 1'b0;
      end
      ST_BLANK1: begin
        digit_sel_d = 1'b1;
      end
      ST_SHOW1: begin
        anode1_n_d   = 1'b0;
        digit_sel_d  = 1'b1;
        frame_tick_d = (cnt_d == CNT_ZERO);
      end
      default: begin
        anode0_n_d = 1'b1;
      end
    endcase
  end

  // State, counter and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= CNT_ZERO;
      s_q          <= 4'h0;
      anode0_n_q   <= 1'b1;
      anode1_n_q   <= 1'b1;
      digit_sel_q  <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      s_q          <= s_d;
      anode0_n_q   <= anode0_n_d;
      anode1_n_q   <= anode1_n_d;
      digit_sel_q  <= digit_sel_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign s          = s_q;
  assign anode0_n   = anode0_n_q;
  assign anode1_n   = anode1_n_q;
  assign digit_sel  = digit_sel_q;
  assign frame_tick = frame_tick_q;

endmodule
